// File: rtl/frontend_pkg.sv
// Frontend shared types: redirect sources, redirect FSM states, flush masks.
package frontend_pkg;

   localparam int ADDR_W  = 32;
   localparam int FLUSH_W = 3;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_BP   = 2'd1,
      SRC_MISP = 2'd2,
      SRC_EXCP = 2'd3
   } redirect_src_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } redirect_state_t;

   localparam logic [FLUSH_W-1:0] FLUSH_ALL = 3'b111;
   localparam logic [FLUSH_W-1:0] FLUSH_IF1 = 3'b001;

   function automatic logic [31:0] sat_add(
      input logic [31:0] c,
      input logic [1:0]  inc
   );
      logic [32:0] s;
      s = {1'b0, c} + {31'b0, inc};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/redirect_pick.sv
// Priority select of the live redirect requests against the pending entry.
module redirect_pick #(
   parameter int ADDR_W = 32
) (
   input  logic              i_excp_req,
   input  logic [ADDR_W-1:0] i_excp_target,
   input  logic              i_misp_req,
   input  logic [ADDR_W-1:0] i_misp_target,
   input  logic              i_bp_req,
   input  logic [ADDR_W-1:0] i_bp_target,
   input  logic [1:0]        i_pend_src,
   input  logic [ADDR_W-1:0] i_pend_addr,
   output logic [1:0]        o_win_src,
   output logic [ADDR_W-1:0] o_win_addr,
   output logic [1:0]        o_cand_src,
   output logic [ADDR_W-1:0] o_cand_addr
);
   import frontend_pkg::*;

   always_comb begin
      o_win_src  = SRC_NONE;
      o_win_addr = '0;
      if (i_excp_req) begin
         o_win_src  = SRC_EXCP;
         o_win_addr = i_excp_target;
      end else if (i_misp_req) begin
         o_win_src  = SRC_MISP;
         o_win_addr = i_misp_target;
      end else if (i_bp_req) begin
         o_win_src  = SRC_BP;
         o_win_addr = i_bp_target;
      end
   end

   // ties go to the new request: it carries the newer address
   always_comb begin
      o_cand_src  = i_pend_src;
      o_cand_addr = i_pend_addr;
      if (o_win_src != SRC_NONE && o_win_src >= i_pend_src) begin
         o_cand_src  = o_win_src;
         o_cand_addr = o_win_addr;
      end
   end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect sequencer: arbitrate, hold under pause, pulse, drain.
// Optional perf counters under `REDIRECT_PERF_EN.
module fetch_redirect_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_W      = 3,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         pause,
   input  logic               excp_req_i,
   input  logic [ADDR_W-1:0]  excp_target_i,
   input  logic               misp_req_i,
   input  logic [ADDR_W-1:0]  misp_target_i,
   input  logic               bp_req_i,
   input  logic [ADDR_W-1:0]  bp_target_i,
   output logic               redirect_valid_o,
   output logic [ADDR_W-1:0]  redirect_addr_o,
   output logic [1:0]         redirect_src_o,
   output logic [FLUSH_W-1:0] flush_o,
   output logic               fetch_en_o
`ifdef REDIRECT_PERF_EN
   ,
   output logic [31:0]        perf_excp_cnt_o,
   output logic [31:0]        perf_misp_cnt_o,
   output logic [31:0]        perf_bp_cnt_o,
   output logic [31:0]        perf_drop_cnt_o
`endif
);
   import frontend_pkg::*;

   localparam int CNT_W =
      (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   redirect_state_t   r_state, w_state_nxt;
   logic [1:0]        r_pend_src, w_pend_src_nxt;
   logic [ADDR_W-1:0] r_pend_addr, w_pend_addr_nxt;
   logic [1:0]        r_last_src, w_last_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_src;
   logic [FLUSH_W-1:0] r_flush;
   logic              r_fetch_en;

   logic              w_pause;
   logic              w_unused_pause;
   logic [1:0]        w_win_src, w_cand_src;
   logic [ADDR_W-1:0] w_win_addr, w_cand_addr;
   logic              w_take;
   logic              w_issue;
   logic [1:0]        w_iss_src;
   logic [ADDR_W-1:0] w_iss_addr;
   logic [FLUSH_W-1:0] w_iss_flush;

   assign w_pause        = pause[0];
   assign w_unused_pause = ^pause[5:1];

   redirect_pick #(.ADDR_W(ADDR_W)) u_pick (
      .i_excp_req    (excp_req_i),
      .i_excp_target (excp_target_i),
      .i_misp_req    (misp_req_i),
      .i_misp_target (misp_target_i),
      .i_bp_req      (bp_req_i),
      .i_bp_target   (bp_target_i),
      .i_pend_src    (r_pend_src),
      .i_pend_addr   (r_pend_addr),
      .o_win_src     (w_win_src),
      .o_win_addr    (w_win_addr),
      .o_cand_src    (w_cand_src),
      .o_cand_addr   (w_cand_addr)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_pend_src_nxt  = r_pend_src;
      w_pend_addr_nxt = r_pend_addr;
      w_last_nxt      = r_last_src;
      w_cnt_nxt       = r_cnt;
      w_take          = 1'b0;
      w_issue         = 1'b0;
      w_iss_src       = SRC_NONE;
      w_iss_addr      = '0;
      unique case (r_state)
         ST_HOLD: begin
            w_take = (w_win_src != SRC_NONE) &&
                     (w_win_src >= r_pend_src);
            w_pend_src_nxt  = w_cand_src;
            w_pend_addr_nxt = w_cand_addr;
            if (!w_pause) begin
               w_issue    = 1'b1;
               w_iss_src  = w_cand_src;
               w_iss_addr = w_cand_addr;
            end
         end
         ST_IDLE, ST_DRAIN: begin
            // in drain, only same-or-higher priority than the last issue
            w_take = (w_win_src != SRC_NONE) &&
                     (r_state == ST_IDLE || w_win_src >= r_last_src);
            if (w_take && !w_pause) begin
               w_issue    = 1'b1;
               w_iss_src  = w_win_src;
               w_iss_addr = w_win_addr;
            end else if (w_take) begin
               w_pend_src_nxt  = w_win_src;
               w_pend_addr_nxt = w_win_addr;
               w_state_nxt     = ST_HOLD;
               w_cnt_nxt       = '0;
            end else if (r_state == ST_DRAIN) begin
               if (r_cnt <= CNT_ONE) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt - CNT_ONE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_issue) begin
         w_pend_src_nxt  = SRC_NONE;
         w_pend_addr_nxt = '0;
         w_last_nxt      = w_iss_src;
         if (DRAIN_CYCLES == 0) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end else begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = DRAIN_INIT;
         end
      end
   end

   assign w_iss_flush = (w_iss_src == SRC_BP) ?
                        FLUSH_W'(FLUSH_IF1) : {FLUSH_W{1'b1}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_pend_src  <= SRC_NONE;
         r_pend_addr <= '0;
         r_last_src  <= SRC_NONE;
         r_cnt       <= '0;
         r_valid     <= 1'b0;
         r_addr      <= '0;
         r_src       <= SRC_NONE;
         r_flush     <= '0;
         r_fetch_en  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pend_src  <= w_pend_src_nxt;
         r_pend_addr <= w_pend_addr_nxt;
         r_last_src  <= w_last_nxt;
         r_cnt       <= w_cnt_nxt;
         r_valid     <= w_issue;
         r_addr      <= {w_iss_addr[ADDR_W-1:2], 2'b00};
         r_src       <= w_iss_src;
         r_flush     <= w_issue ? w_iss_flush : '0;
         r_fetch_en  <= (w_state_nxt != ST_DRAIN);
      end
   end

   assign redirect_valid_o = r_valid;
   assign redirect_addr_o  = r_addr;
   assign redirect_src_o   = r_src;
   assign flush_o          = r_flush;
   assign fetch_en_o       = r_fetch_en;

`ifdef REDIRECT_PERF_EN
   logic [31:0] r_perf_excp, r_perf_misp, r_perf_bp, r_perf_drop;
   logic [1:0]  w_ndrop;

   // every request not taken this cycle counts as discarded
   assign w_ndrop = ({1'b0, excp_req_i} + {1'b0, misp_req_i} +
                     {1'b0, bp_req_i}) - {1'b0, w_take};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_excp <= '0;
         r_perf_misp <= '0;
         r_perf_bp   <= '0;
         r_perf_drop <= '0;
      end else begin
         if (w_issue && w_iss_src == SRC_EXCP)
            r_perf_excp <= sat_add(r_perf_excp, 2'd1);
         if (w_issue && w_iss_src == SRC_MISP)
            r_perf_misp <= sat_add(r_perf_misp, 2'd1);
         if (w_issue && w_iss_src == SRC_BP)
            r_perf_bp <= sat_add(r_perf_bp, 2'd1);
         r_perf_drop <= sat_add(r_perf_drop, w_ndrop);
      end
   end

   assign perf_excp_cnt_o = r_perf_excp;
   assign perf_misp_cnt_o = r_perf_misp;
   assign perf_bp_cnt_o   = r_perf_bp;
   assign perf_drop_cnt_o = r_perf_drop;
`endif

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences every PC redirect into the dual-issue PC register.
- Arbitrates three redirect sources: exception/ertn, backend branch mispredict, and decode-stage predictor redirect.
- Holds the winning redirect while fetch is paused, then issues it as a single-cycle pulse with a matching flush mask.
- Drives the fetch enable and blanks fetch for a fixed drain window after each redirect.

Parameters:
- ADDR_W, 32, instruction address width.
- FLUSH_W, 3, frontend stage flush mask width (bit0 IF1, bit1 IF2, bit2 ID).
- DRAIN_CYCLES, 2, fetch-blank cycles after an issued redirect; 0 disables drain.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- pause  in  6  pipeline pause vector; only pause[0] (PC stage stall) is used.
- excp_req_i  in  1  exception/ertn redirect request.
- excp_target_i  in  ADDR_W  exception/ertn target.
- misp_req_i  in  1  backend mispredict redirect request.
- misp_target_i  in  ADDR_W  corrected target.
- bp_req_i  in  1  predictor-taken redirect from decode.
- bp_target_i  in  ADDR_W  predicted target.
- redirect_valid_o  out  1  one-cycle redirect pulse to the PC register.
- redirect_addr_o  out  ADDR_W  redirect address; bits [1:0] forced to 0.
- redirect_src_o  out  2  source code: 3 = EXCP, 2 = MISP, 1 = BP, 0 = none.
- flush_o  out  FLUSH_W  stage flush mask, valid with redirect_valid_o.
- fetch_en_o  out  1  instruction fetch enable.

Behaviour:
- Priority: EXCP > MISP > BP. win = highest-priority asserted request this cycle.
- cand = higher-priority of win and the pending entry; on a tie, the new request replaces the pending one (newer address).
- All outputs are registered.
- Reset values: redirect_valid_o = 0, redirect_addr_o = 0, redirect_src_o = 0, flush_o = 0, fetch_en_o = 0, state = IDLE, pending cleared, drain counter = 0.
- fetch_en_o rises on the first clock edge after reset deasserts.
- An issue asserts redirect_valid_o for exactly one cycle, with addr/src of the issued entry:
  - flush_o = all ones for EXCP or MISP.
  - flush_o = 3'b001 for BP.
- Latency: request in cycle n with pause[0] = 0 → pulse in cycle n+1.
- States:
  - IDLE:
    - win != 0 and pause[0] = 0 → issue win; go to DRAIN with cnt = DRAIN_CYCLES (go to IDLE if DRAIN_CYCLES = 0).
    - win != 0 and pause[0] = 1 → latch into pending; go to HOLD.
  - HOLD:
    - Pending updated to cand every cycle.
    - pause[0] = 0 → issue cand, clear pending, go to DRAIN.
    - A lower-priority request arriving in HOLD is dropped.
  - DRAIN:
    - fetch_en_o = 0; cnt decrements each cycle; at cnt = 1 the next state is IDLE and fetch_en_o returns to 1.
    - A request with src >= last issued src is handled exactly as in IDLE: issue or HOLD, counter restarted.
    - BP requests during drain after an EXCP/MISP issue are dropped as wrong-path.
- Simultaneous requests in one cycle: only the winner is considered; losers are discarded, not queued.
- Reset mid-operation (HOLD or DRAIN): state, pending and outputs return to reset values immediately (asynchronous); no pulse is emitted.

Optional Feature:
- Macro: REDIRECT_PERF_EN.
- When defined:
  - Adds outputs perf_excp_cnt_o, perf_misp_cnt_o, perf_bp_cnt_o (32 bits each), plus perf_drop_cnt_o counting discarded requests.
  - Each counter increments once per issued redirect of that source (drop counter: once per dropped request), saturates at 32'hFFFF_FFFF, and resets to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package frontend_pkg:
  - ADDR_W.
  - redirect_src_t enum (NONE, BP, MISP, EXCP).
  - redirect_state_t enum (IDLE, HOLD, DRAIN).
  - FLUSH_ALL / FLUSH_IF1 constants.
- One sub-module, redirect_pick: purely combinational priority select of the three requests plus the pending entry, producing cand src/addr.

Test Plan:
- MISP 32'h1C00_0100 alone, pause = 0 → next cycle: pulse, addr 32'h1C00_0100, src 2, flush 3'b111; fetch_en_o low for 2 cycles, then 1.
- EXCP 32'h1C00_8000 and BP 32'h1C00_0040 in the same cycle → single pulse, src 3, addr 32'h1C00_8000; BP never issued.
- BP 32'h40 while pause[0] = 1, then MISP 32'h80 the next cycle, pause released on cycle 3 → one pulse in cycle 4, addr 32'h80, src 2.
- MISP issued, then BP during DRAIN → BP dropped, no second pulse; EXCP during DRAIN → reissued, drain counter restarted.
- Target 32'h1C00_0103 → redirect_addr_o = 32'h1C00_0100.
- rst driven low while in HOLD → all outputs 0 immediately; after release, fetch_en_o = 1 next edge and no stale pulse.
